// File: rtl/alu_mc_n.sv
`default_nettype none
// ============================================================================
// Module  : alu_mc_n
// Brief   : Multi-cycle ALU. Single-cycle logic/arith ops, shift-add signed
//           multiply and restoring signed divide behind start/busy/done.
//           Optional macro ALU_MC_EARLY_TERM_EN: early exit of MUL CALC.
// Revision: 1.0 - initial release
// ============================================================================
module alu_mc_n #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [4:0]       FS,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] T,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Y_hi,
    output logic [WIDTH-1:0] Y_lo,
    output logic             N,
    output logic             Z,
    output logic             V,
    output logic             C
);

    localparam int MSB = WIDTH - 1;

    localparam logic [4:0] FS_PASS_S = 5'h00;
    localparam logic [4:0] FS_PASS_T = 5'h01;
    localparam logic [4:0] FS_ADD    = 5'h02;
    localparam logic [4:0] FS_ADDU   = 5'h03;
    localparam logic [4:0] FS_SUB    = 5'h04;
    localparam logic [4:0] FS_SUBU   = 5'h05;
    localparam logic [4:0] FS_SLT    = 5'h06;
    localparam logic [4:0] FS_SLTU   = 5'h07;
    localparam logic [4:0] FS_AND    = 5'h08;
    localparam logic [4:0] FS_OR     = 5'h09;
    localparam logic [4:0] FS_XOR    = 5'h0A;
    localparam logic [4:0] FS_NOR    = 5'h0B;
    localparam logic [4:0] FS_SRL    = 5'h0C;
    localparam logic [4:0] FS_SRA    = 5'h0D;
    localparam logic [4:0] FS_SLL    = 5'h0E;
    localparam logic [4:0] FS_INC    = 5'h13;
    localparam logic [4:0] FS_DEC    = 5'h14;
    localparam logic [4:0] FS_ZEROS  = 5'h17;
    localparam logic [4:0] FS_ONES   = 5'h18;
    localparam logic [4:0] FS_MUL    = 5'h1E;
    localparam logic [4:0] FS_DIV    = 5'h1F;

    localparam logic [WIDTH-1:0] C_MIN      = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] C_ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [SHW-1:0]   C_CNT_LAST = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   b_q, b_d, m_q, m_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic               is_div_q, is_div_d, qneg_q, qneg_d, rneg_q, rneg_d, ovf_q, ovf_d;
    logic [WIDTH-1:0]   yhi_q, yhi_d, ylo_q, ylo_d;
    logic               n_q, n_d, z_q, z_d, v_q, v_d, c_q, c_d, done_q, done_d;

    logic [WIDTH:0]     w_add, w_sub, w_inc, w_dec;
    logic [WIDTH-1:0]   w_sc_hi, w_sc_lo, w_abs_s, w_abs_t;
    logic               w_sc_v, w_sc_c, w_long_op;
    logic [SHW-1:0]     w_shamt;
    logic [WIDTH-1:0]   w_rem_sh, w_q, w_r;
    logic [WIDTH:0]     w_diff, w_hi_sum;
    logic [2*WIDTH-1:0] w_prod, w_fix;

    assign w_shamt   = S[SHW-1:0];
    assign w_add     = {1'b0, S} + {1'b0, T};
    assign w_sub     = {1'b0, S} + {1'b0, ~T} + {1'b0, C_ONE};
    assign w_inc     = {1'b0, S} + {1'b0, C_ONE};
    assign w_dec     = {1'b0, S} + {1'b0, {WIDTH{1'b1}}};
    assign w_abs_s   = S[MSB] ? -S : S;
    assign w_abs_t   = T[MSB] ? -T : T;
    assign w_long_op = (FS == FS_MUL) || ((FS == FS_DIV) && (T != '0));

    always_comb begin : p_single
        w_sc_hi = '0;
        w_sc_lo = '0;
        w_sc_v  = 1'b0;
        w_sc_c  = 1'b0;
        case (FS)
            FS_PASS_S: w_sc_lo = S;
            FS_PASS_T: w_sc_lo = T;
            FS_ADD: begin
                w_sc_lo = w_add[WIDTH-1:0];
                w_sc_v  = (S[MSB] == T[MSB]) && (w_add[MSB] != S[MSB]);
                w_sc_c  = w_add[WIDTH];
            end
            FS_ADDU: begin
                w_sc_lo = w_add[WIDTH-1:0];
                w_sc_c  = w_add[WIDTH];
            end
            FS_SUB: begin
                w_sc_lo = w_sub[WIDTH-1:0];
                w_sc_v  = (S[MSB] != T[MSB]) && (w_sub[MSB] != S[MSB]);
                w_sc_c  = w_sub[WIDTH];
            end
            FS_SUBU: begin
                w_sc_lo = w_sub[WIDTH-1:0];
                w_sc_c  = w_sub[WIDTH];
            end
            FS_SLT:   w_sc_lo = {{(WIDTH-1){1'b0}}, ($signed(S) < $signed(T))};
            FS_SLTU:  w_sc_lo = {{(WIDTH-1){1'b0}}, (S < T)};
            FS_AND:   w_sc_lo = S & T;
            FS_OR:    w_sc_lo = S | T;
            FS_XOR:   w_sc_lo = S ^ T;
            FS_NOR:   w_sc_lo = ~(S | T);
            FS_SRL:   w_sc_lo = T >> w_shamt;
            FS_SRA:   w_sc_lo = $unsigned($signed(T) >>> w_shamt);
            FS_SLL:   w_sc_lo = T << w_shamt;
            FS_INC: begin
                w_sc_lo = w_inc[WIDTH-1:0];
                w_sc_v  = ~S[MSB] & w_inc[MSB];
                w_sc_c  = w_inc[WIDTH];
            end
            FS_DEC: begin
                w_sc_lo = w_dec[WIDTH-1:0];
                w_sc_v  = S[MSB] & ~w_dec[MSB];
                w_sc_c  = w_dec[WIDTH];
            end
            FS_ZEROS: w_sc_lo = '0;
            FS_ONES:  w_sc_lo = '1;
            // Only selected when T==0; a non-zero divisor goes multi-cycle.
            FS_DIV: begin
                w_sc_hi = S;
                w_sc_lo = '1;
                w_sc_v  = 1'b1;
            end
            default: w_sc_lo = '0;
        endcase
    end

    always_comb begin : p_next
        state_d  = state_q;
        acc_d    = acc_q;
        b_d      = b_q;
        m_d      = m_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        ovf_d    = ovf_q;
        yhi_d    = yhi_q;
        ylo_d    = ylo_q;
        n_d      = n_q;
        z_d      = z_q;
        v_d      = v_q;
        c_d      = c_q;
        done_d   = 1'b0;
        w_rem_sh = {acc_q[2*WIDTH-2:WIDTH], acc_q[WIDTH-1]};
        w_diff   = {1'b0, w_rem_sh} - {1'b0, b_q};
        w_hi_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (m_q[0] ? {1'b0, b_q} : '0);
        w_prod   = {w_hi_sum, acc_q[WIDTH-1:1]};
        w_fix    = qneg_q ? -acc_q : acc_q;
        w_q      = qneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        w_r      = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

        case (state_q)
            ST_IDLE: begin
                if (start && w_long_op) begin
                    state_d  = ST_CALC;
                    cnt_d    = '0;
                    is_div_d = (FS == FS_DIV);
                    qneg_d   = S[MSB] ^ T[MSB];
                    rneg_d   = S[MSB];
                    ovf_d    = (FS == FS_DIV) && (S == C_MIN) && (T == '1);
                    if (FS == FS_DIV) begin
                        acc_d = {{WIDTH{1'b0}}, w_abs_s};
                        b_d   = w_abs_t;
                    end else begin
                        acc_d = '0;
                        b_d   = w_abs_s;
                        m_d   = w_abs_t;
                    end
                end else if (start) begin
                    yhi_d  = w_sc_hi;
                    ylo_d  = w_sc_lo;
                    n_d    = w_sc_lo[MSB];
                    z_d    = (w_sc_lo == '0);
                    v_d    = w_sc_v;
                    c_d    = w_sc_c;
                    done_d = 1'b1;
                end
            end
            ST_CALC: begin
                if (is_div_q) begin
                    if (!w_diff[WIDTH]) begin
                        acc_d = {w_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = {w_rem_sh, acc_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_d = w_prod;
                    m_d   = m_q >> 1;
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == C_CNT_LAST) begin
                    state_d = ST_FIX;
                end
`ifdef ALU_MC_EARLY_TERM_EN
                // Remaining steps would only shift; apply them all at once.
                if (!is_div_q && (m_d == '0)) begin
                    acc_d   = w_prod >> (C_CNT_LAST - cnt_q);
                    state_d = ST_FIX;
                end
`endif
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                c_d     = 1'b0;
                if (is_div_q) begin
                    yhi_d = w_r;
                    ylo_d = w_q;
                    n_d   = w_q[MSB];
                    z_d   = (w_q == '0);
                    v_d   = ovf_q;
                end else begin
                    yhi_d = w_fix[2*WIDTH-1:WIDTH];
                    ylo_d = w_fix[WIDTH-1:0];
                    n_d   = w_fix[2*WIDTH-1];
                    z_d   = (w_fix == '0);
                    v_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            b_q      <= '0;
            m_q      <= '0;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            ovf_q    <= 1'b0;
            yhi_q    <= '0;
            ylo_q    <= '0;
            n_q      <= 1'b0;
            z_q      <= 1'b0;
            v_q      <= 1'b0;
            c_q      <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            b_q      <= b_d;
            m_q      <= m_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            ovf_q    <= ovf_d;
            yhi_q    <= yhi_d;
            ylo_q    <= ylo_d;
            n_q      <= n_d;
            z_q      <= z_d;
            v_q      <= v_d;
            c_q      <= c_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign Y_hi = yhi_q;
    assign Y_lo = ylo_q;
    assign N    = n_q;
    assign Z    = z_q;
    assign V    = v_q;
    assign C    = c_q;

endmodule
`default_nettype wire
